// File: rtl/math_operation.sv
// Three-stage pipelined evaluation of F(x, y) = x*x + 2*x*y - y*y on 4-bit signed operands.
// The result port is named final_val because "final" is a reserved SystemVerilog keyword.
module math_operation (
   input  logic              clk,
   input  logic              rst_n,
   input  logic signed [3:0] x,
   input  logic signed [3:0] y,
   output logic signed [8:0] final_val
);

   // 4x4 signed multiply from sign-extended partial products; the MSB of b carries weight -8.
   function automatic logic signed [7:0] smul4(input logic signed [3:0] a,
                                                input logic signed [3:0] b);
      logic [7:0] a_ext;
      logic [7:0] pp0;
      logic [7:0] pp1;
      logic [7:0] pp2;
      logic [7:0] pp3;
      a_ext = {{4{a[3]}}, a};
      pp0   = b[0] ? a_ext : 8'd0;
      pp1   = b[1] ? (a_ext << 1) : 8'd0;
      pp2   = b[2] ? (a_ext << 2) : 8'd0;
      pp3   = b[3] ? (~(a_ext << 3) + 8'd1) : 8'd0;
      return signed'(pp0 + pp1 + pp2 + pp3);
   endfunction

   logic signed [3:0] x_s1;
   logic signed [3:0] y_s1;
   logic signed [7:0] p_xx;
   logic signed [8:0] p_xy2;
   logic signed [7:0] p_yy;

   logic signed [7:0] m_xx;
   logic signed [7:0] m_xy;
   logic signed [7:0] m_yy;
   logic        [9:0] sum;

   always_comb begin
      m_xx = smul4(x_s1, x_s1);
      m_xy = smul4(x_s1, y_s1);
      m_yy = smul4(y_s1, y_s1);
   end

   // Ten bits of headroom for the sum; the result range -127..128 makes the 9-bit truncation exact.
   always_comb begin
      sum = {{2{p_xx[7]}}, p_xx} + {p_xy2[8], p_xy2} - {{2{p_yy[7]}}, p_yy};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_s1      <= '0;
         y_s1      <= '0;
         p_xx      <= '0;
         p_xy2     <= '0;
         p_yy      <= '0;
         final_val <= '0;
      end else begin
         x_s1      <= x;
         y_s1      <= y;
         p_xx      <= m_xx;
         p_xy2     <= {m_xy, 1'b0};
         p_yy      <= m_yy;
         final_val <= signed'(sum[8:0]);
      end
   end

endmodule

// File: tb/tb_math_operation.sv
// Scoreboard bench for math_operation: the driver queues expected results, the monitor checks them.
module tb_math_operation;

   logic              clk;
   logic              rst_n;
   logic signed [3:0] x;
   logic signed [3:0] y;
   logic signed [8:0] final_val;

   typedef struct {
      int due;
      int exp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   math_operation dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (x),
      .y         (y),
      .final_val (final_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic int model(input int xv, input int yv);
      return xv * xv + 2 * xv * yv - yv * yv;
   endfunction

   task automatic check(input string name, input int exp);
      n_cmp = n_cmp + 1;
      if (int'(final_val) != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, final_val, exp, cyc);
      end
   endtask

   // Operands change on the falling edge and are sampled by the next rising edge (cyc+1);
   // the result becomes visible after rising edge cyc+3.
   task automatic drive(input int xv, input int yv);
      exp_t e;
      @(negedge clk);
      x     = 4'(xv);
      y     = 4'(yv);
      e.due = cyc + 3;
      e.exp = model(xv, yv);
      q.push_back(e);
   endtask

   task automatic mid_reset(input int xv, input int yv);
      exp_t e;
      drive(xv, yv);
      #2 rst_n = 1'b0;
      #1 check("midreset_async_zero", 0);
      q.delete();
      #1 rst_n = 1'b1;
      e.due = cyc + 1; e.exp = 0;            q.push_back(e);
      e.due = cyc + 2; e.exp = 0;            q.push_back(e);
      e.due = cyc + 3; e.exp = model(xv, yv); q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
               e = q.pop_front();
               n_cmp = n_cmp + 1;
               n_bad = n_bad + 1;
               $display("FAIL missed_result: expected %0d due at cycle %0d, now cycle %0d",
                        e.exp, e.due, cyc);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
               e = q.pop_front();
               check("pipeline_result", e.exp);
            end
         end
      end
   end

   int dir_x[11] = '{5, 6, 7, 4, -4, -3, -1, -1, 5, 5, 5};
   int dir_y[11] = '{-6, -5, -1, -6, -5, -2, -6, 6, 2, 5, 3};
   int ext_x[4]  = '{-8, 7, -8, 7};
   int ext_y[4]  = '{-8, -8, 7, 7};

   initial begin : driver
      int wait_cyc;
      rst_n = 1'b0;
      x     = 4'(($urandom_range(0, 15)));
      y     = 4'(($urandom_range(0, 15)));
      #3 check("reset_async_zero", 0);
      repeat (2) @(posedge clk);
      #1 check("reset_held_zero", 0);
      @(negedge clk);
      x = '0;
      y = '0;
      #2 rst_n = 1'b1;

      repeat (4) drive(0, 0);

      foreach (dir_x[i]) repeat (3) drive(dir_x[i], dir_y[i]);
      foreach (ext_x[i]) repeat (3) drive(ext_x[i], ext_y[i]);

      foreach (dir_x[i]) drive(dir_x[i], dir_y[i]);
      foreach (ext_x[i]) drive(ext_x[i], ext_y[i]);

      mid_reset(5, -6);
      foreach (dir_x[i]) drive(dir_x[i], dir_y[i]);
      drive(7, -8);
      mid_reset(-8, -8);
      drive(-1, 6);

      for (int xv = -8; xv <= 7; xv++)
         for (int yv = -8; yv <= 7; yv++)
            drive(xv, yv);

      repeat (200) drive(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (q.size() > 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
